// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults and frame geometry helper for the convolution collector
package conv_pkg;

  localparam int DEF_CH    = 3;
  localparam int DEF_DW    = 8;
  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  localparam int DEF_K     = 3;

  // Number of window positions kept per frame for a given raster, kernel and stride.
  function automatic int kept_per_frame(input int img_w, input int img_h,
                                        input int k, input int stride);
    return ((img_h - k) / stride + 1) * ((img_w - k) / stride + 1);
  endfunction

endpackage

// File: rtl/conv_fifo.sv
// rtl/conv_fifo.sv - first-word fall-through FIFO with wrap-bit pointers
module conv_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Same index with opposite wrap bits means the write pointer has lapped the read pointer.
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset empties the queue regardless of contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are never reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/conv_collector.sv
// rtl/conv_collector.sv - keeps strided valid-window convolution beats and queues them downstream
module conv_collector
  import conv_pkg::*;
#(
  parameter int CH     = DEF_CH,
  parameter int DW     = DEF_DW,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int STRIDE = 1,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [CH*DW-1:0]             in_data,
  input  logic                         frame_start,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [CH*DW-1:0]             out_data,
  output logic                         out_last,
  output logic                         frame_done,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LAST_ROW = (K - 1) + ((IMG_H - K) / STRIDE) * STRIDE;
  localparam int LAST_COL = (K - 1) + ((IMG_W - K) / STRIDE) * STRIDE;

  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [RW-1:0]    cur_row;
  logic [CW-1:0]    cur_col;
  logic             accept;
  logic             keep;
  logic             is_last;
  logic             full;
  logic             empty;
  logic [CH*DW:0]   head;

  assign accept  = in_vld && in_rdy;
  // A beat arriving with frame_start belongs to the new frame's origin.
  assign cur_row = frame_start ? '0 : row;
  assign cur_col = frame_start ? '0 : col;

  // Keep decision for the window whose bottom-right corner is at the current position.
  always_comb begin
    keep    = 1'b0;
    is_last = 1'b0;
    if ((int'(cur_row) >= K - 1) && (int'(cur_col) >= K - 1)) begin
      keep = ((int'(cur_row) - (K - 1)) % STRIDE == 0) &&
             ((int'(cur_col) - (K - 1)) % STRIDE == 0);
    end
    is_last = keep && (int'(cur_row) == LAST_ROW) && (int'(cur_col) == LAST_COL);
  end

  // Raster position tracking in row-major order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (int'(cur_col) == IMG_W - 1) begin
        col <= '0;
        row <= (int'(cur_row) == IMG_H - 1) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end else if (frame_start) begin
      row <= '0;
      col <= '0;
    end
  end

  conv_fifo #(
    .W     (CH*DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && keep),
    .wdata ({is_last, in_data}),
    .pop   (out_rdy),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign in_rdy   = !full;
  assign out_vld  = !empty;
  assign out_data = head[CH*DW-1:0];
  assign out_last = head[CH*DW] && !empty;

  // One-cycle pulse after the frame's final kept beat leaves the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= out_vld && out_rdy && out_last;
  end

endmodule

// File: tb/tb_conv_collector.sv
// tb/tb_conv_collector.sv - scoreboard bench for conv_collector at stride 1 and stride 2
module tb_conv_collector;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int K    = 3;
  localparam int NPIX = W * H;

  typedef logic [24:0] item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_vld0 = 1'b0, fs0 = 1'b0;
  logic [23:0] in_data0 = '0;
  logic        in_rdy0, out_vld0, out_last0, fd0;
  logic [23:0] out_data0;
  logic [3:0]  level0;
  logic        rdy_fixed = 1'b1, rdy_rand = 1'b0, rand_en = 1'b0;
  logic        out_rdy0;

  logic        in_vld1 = 1'b0, fs1 = 1'b0;
  logic [23:0] in_data1 = '0;
  logic        in_rdy1, out_vld1, out_last1, fd1;
  logic [23:0] out_data1;
  logic [3:0]  level1;
  logic        out_rdy1 = 1'b1;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  item_t       sb0[$], sb1[$];
  item_t       e0, e1;
  int          pos0 = 0, pos1 = 0;
  int          nout0 = 0, nout1 = 0, nfd0 = 0, nfd1 = 0;
  bit          exp_fd0 = 0, exp_fd1 = 0;
  logic [23:0] last_data0 = '0, last_data1 = '0;
  int          push_cyc0 = -1, vld_cyc0 = -1;
  int          bo, bf;

  assign out_rdy0 = rand_en ? rdy_rand : rdy_fixed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdy_rand <= 1'($urandom_range(0, 1));

  conv_collector #(.STRIDE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld0), .in_rdy(in_rdy0), .in_data(in_data0),
    .frame_start(fs0), .out_vld(out_vld0), .out_rdy(out_rdy0), .out_data(out_data0),
    .out_last(out_last0), .frame_done(fd0), .level(level0));

  conv_collector #(.STRIDE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1),
    .frame_start(fs1), .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1),
    .out_last(out_last1), .frame_done(fd1), .level(level1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic bit kept(input int p, input int stride);
    int r, c;
    r = p / W;
    c = p % W;
    return (r >= K - 1) && (c >= K - 1) && ((r - K + 1) % stride == 0) && ((c - K + 1) % stride == 0);
  endfunction

  function automatic int last_kept(input int stride);
    int l = -1;
    for (int p = 0; p < NPIX; p++) if (kept(p, stride)) l = p;
    return l;
  endfunction

  task automatic model_accept(input int sel, input logic [23:0] d, input bit fs);
    int p;
    if (sel == 0) begin
      if (fs) pos0 = 0;
      p = pos0;
      if (kept(p, 1)) begin
        sb0.push_back({p == last_kept(1), d});
        if (push_cyc0 < 0) push_cyc0 = cyc;
      end
      pos0 = (pos0 + 1) % NPIX;
    end else begin
      if (fs) pos1 = 0;
      p = pos1;
      if (kept(p, 2)) sb1.push_back({p == last_kept(2), d});
      pos1 = (pos1 + 1) % NPIX;
    end
  endtask

  task automatic drive_beat(input int sel, input logic [23:0] d, input bit fs);
    int t = 0;
    bit done = 0;
    if (sel == 0) begin in_vld0 = 1'b1; in_data0 = d; fs0 = fs; end
    else          begin in_vld1 = 1'b1; in_data1 = d; fs1 = fs; end
    while (!done) begin
      @(negedge clk);
      if ((sel == 0) ? in_rdy0 : in_rdy1) begin
        model_accept(sel, d, fs);
        done = 1;
      end else if (++t > 200) begin
        check("in_rdy_timeout", 0, 1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    if (sel == 0) begin in_vld0 = 1'b0; fs0 = 1'b0; end
    else          begin in_vld1 = 1'b0; fs1 = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int sel);
    int t = 0;
    while (((sel == 0) ? (sb0.size() != 0 || out_vld0) : (sb1.size() != 0 || out_vld1)) && t < 500) begin
      idle(1);
      t++;
    end
    if (t >= 500) check("drain_timeout", 0, 1);
    idle(2);
  endtask

  // Monitor for the stride-1 instance: pop expected beat on every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_fd0 = 0;
    end else begin
      if (fd0 || exp_fd0) check("frame_done0", 32'(fd0), 32'(exp_fd0));
      if (fd0) nfd0++;
      exp_fd0 = 0;
      if (out_vld0 && vld_cyc0 < 0) vld_cyc0 = cyc;
      if (out_vld0 && out_rdy0) begin
        if (sb0.size() == 0) begin
          check("out0_unexpected", 32'(out_data0), 32'hFFFF_FFFF);
        end else begin
          e0 = sb0.pop_front();
          check("out0_data", 32'(out_data0), 32'(e0[23:0]));
          check("out0_last", 32'(out_last0), 32'(e0[24]));
        end
        nout0++;
        if (out_last0) begin exp_fd0 = 1; last_data0 = out_data0; end
      end
    end
  end

  // Monitor for the stride-2 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_fd1 = 0;
    end else begin
      if (fd1 || exp_fd1) check("frame_done1", 32'(fd1), 32'(exp_fd1));
      if (fd1) nfd1++;
      exp_fd1 = 0;
      if (out_vld1 && out_rdy1) begin
        if (sb1.size() == 0) begin
          check("out1_unexpected", 32'(out_data1), 32'hFFFF_FFFF);
        end else begin
          e1 = sb1.pop_front();
          check("out1_data", 32'(out_data1), 32'(e1[23:0]));
          check("out1_last", 32'(out_last1), 32'(e1[24]));
        end
        nout1++;
        if (out_last1) begin exp_fd1 = 1; last_data1 = out_data1; end
      end
    end
  end

  initial begin
    idle(3);
    check("rst_out_vld0", 32'(out_vld0), 0);
    check("rst_out_last0", 32'(out_last0), 0);
    check("rst_level0", 32'(level0), 0);
    check("rst_frame_done0", 32'(fd0), 0);
    check("rst_out_vld1", 32'(out_vld1), 0);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_in_rdy0", 32'(in_rdy0), 1);
    check("post_rst_in_rdy1", 32'(in_rdy1), 1);

    // Full frame, index data, always ready.
    bo = nout0; bf = nfd0;
    for (int i = 0; i < 64; i++) drive_beat(0, 24'(i), 0);
    wait_drain(0);
    check("f1_count", 32'(nout0 - bo), 36);
    check("f1_frame_done", 32'(nfd0 - bf), 1);
    check("f1_last_data", 32'(last_data0), 63);
    check("f1_latency", 32'(vld_cyc0 - push_cyc0), 1);

    // Stride 2 frame.
    bo = nout1; bf = nfd1;
    for (int i = 0; i < 64; i++) drive_beat(1, 24'(i), 0);
    wait_drain(1);
    check("s2_count", 32'(nout1 - bo), 9);
    check("s2_frame_done", 32'(nfd1 - bf), 1);
    check("s2_last_data", 32'(last_data1), 54);

    // Random data, random gaps, random downstream backpressure.
    bo = nout0; bf = nfd0;
    rand_en = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 64; i++) begin
        idle($urandom_range(0, 2));
        drive_beat(0, 24'($urandom), 0);
      end
    rand_en = 1'b0; rdy_fixed = 1'b1;
    wait_drain(0);
    check("rand_count", 32'(nout0 - bo), 72);
    check("rand_frame_done", 32'(nfd0 - bf), 2);

    bo = nout1; bf = nfd1;
    for (int i = 0; i < 64; i++) begin
      idle($urandom_range(0, 3));
      drive_beat(1, 24'($urandom), 0);
    end
    wait_drain(1);
    check("s2_rand_count", 32'(nout1 - bo), 9);
    check("s2_rand_frame_done", 32'(nfd1 - bf), 1);

    // Fill to full with downstream stalled, then release.
    bo = nout0; bf = nfd0;
    rdy_fixed = 1'b0;
    for (int i = 0; i < 28; i++) drive_beat(0, 24'(i), 0);
    check("full_level", 32'(level0), 8);
    check("full_in_rdy", 32'(in_rdy0), 0);
    in_vld0 = 1'b1; in_data0 = 24'd28;
    repeat (4) @(negedge clk);
    check("hold_level", 32'(level0), 8);
    check("hold_in_rdy", 32'(in_rdy0), 0);
    @(posedge clk); #1;
    rdy_fixed = 1'b1;
    @(negedge clk);
    check("same_cycle_pop_in_rdy", 32'(in_rdy0), 0);
    @(posedge clk); #1;
    check("pop_no_push_level", 32'(level0), 7);
    check("restored_in_rdy", 32'(in_rdy0), 1);
    for (int i = 28; i < 64; i++) drive_beat(0, 24'(i), 0);
    wait_drain(0);
    check("full_count", 32'(nout0 - bo), 36);
    check("full_frame_done", 32'(nfd0 - bf), 1);

    // frame_start coinciding with beat 30.
    bo = nout0; bf = nfd0;
    for (int i = 0; i < 30; i++) drive_beat(0, 24'(i), 0);
    drive_beat(0, 24'd30, 1);
    for (int i = 31; i < 94; i++) drive_beat(0, 24'(i), 0);
    wait_drain(0);
    check("fs_count", 32'(nout0 - bo), 46);
    check("fs_frame_done", 32'(nfd0 - bf), 1);
    check("fs_last_data", 32'(last_data0), 93);

    // Reset mid-frame with three beats buffered.
    for (int i = 0; i < 37; i++) drive_beat(0, 24'(i), 0);
    idle(3);
    rdy_fixed = 1'b0;
    for (int i = 37; i < 40; i++) drive_beat(0, 24'(i), 0);
    check("pre_rst_level", 32'(level0), 3);
    in_vld0 = 1'b1; in_data0 = 24'd40;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", 32'(out_vld0), 0);
    check("mid_rst_level", 32'(level0), 0);
    check("mid_rst_out_last", 32'(out_last0), 0);
    sb0.delete();
    pos0 = 0;
    idle(2);
    in_vld0 = 1'b0;
    rst_n = 1'b1;
    rdy_fixed = 1'b1;
    idle(1);
    check("mid_rst_in_rdy", 32'(in_rdy0), 1);
    bo = nout0; bf = nfd0;
    for (int i = 0; i < 64; i++) drive_beat(0, 24'(i), 0);
    wait_drain(0);
    check("after_rst_count", 32'(nout0 - bo), 36);
    check("after_rst_frame_done", 32'(nfd0 - bf), 1);
    check("after_rst_last_data", 32'(last_data0), 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
